// File: rtl/encoder_velocity_estimator.sv
// encoder_velocity_estimator
//
// Purpose: turns the free-running quadrature position count into a per-window
// signed velocity (counts per WINDOW_CYCLES clocks), a 2**AVG_LOG2 sample
// moving average of that velocity, and a stall flag for the velocity PI loop.
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-low reset (asserted when 0)
//   enable         run estimator; low returns the block to IDLE
//   encoder_count  position count, synchronous to clk
//   state_change   high on cycles where the encoder state moved
//   velocity       signed counts/window of the latest window, saturated
//   velocity_valid one-cycle pulse when velocity/avg_velocity/saturated update
//   avg_velocity   signed mean (floor) of the last 2**AVG_LOG2 samples
//   avg_valid      level: history full, avg_velocity meaningful
//   saturated      latest sample was clamped to the VEL_WIDTH range
//   stalled        no state_change for STALL_WINDOWS full windows
//   state_dbg      current FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: velocity_valid is a pure one-cycle strobe with no ready/back-
// pressure; consumers must capture velocity, avg_velocity and saturated on
// the cycle it is high. The values then hold until the next strobe.
//
// COUNT_WIDTH is expected to be wider than VEL_WIDTH so the clamp is needed.
module encoder_velocity_estimator #(
    parameter int COUNT_WIDTH   = 32,
    parameter int VEL_WIDTH     = 16,
    parameter int WINDOW_CYCLES = 50000,
    parameter int AVG_LOG2      = 2,
    parameter int STALL_WINDOWS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [COUNT_WIDTH-1:0] encoder_count,
    input  logic                   state_change,
    output logic [VEL_WIDTH-1:0]   velocity,
    output logic                   velocity_valid,
    output logic [VEL_WIDTH-1:0]   avg_velocity,
    output logic                   avg_valid,
    output logic                   saturated,
    output logic                   stalled,
    output logic                   state_dbg
);

    localparam int DEPTH   = 1 << AVG_LOG2;
    localparam int WIN_W   = $clog2(WINDOW_CYCLES);
    localparam int PTR_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int FILL_W  = AVG_LOG2 + 1;
    localparam int STALL_W = $clog2(STALL_WINDOWS + 1);
    localparam int SUM_W   = VEL_WIDTH + AVG_LOG2;

    localparam logic signed [COUNT_WIDTH-1:0] VMAX = COUNT_WIDTH'((1 << (VEL_WIDTH - 1)) - 1);
    localparam logic signed [COUNT_WIDTH-1:0] VMIN = ~VMAX;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic [WIN_W-1:0]             win_q, win_d;
    logic [COUNT_WIDTH-1:0]       base_q, base_d;
    logic signed [VEL_WIDTH-1:0]  velocity_q, velocity_d;
    logic                         vel_valid_q, vel_valid_d;
    logic signed [VEL_WIDTH-1:0]  avg_q, avg_d;
    logic                         avg_valid_q, avg_valid_d;
    logic                         sat_q, sat_d;
    logic                         stalled_q, stalled_d;
    logic signed [VEL_WIDTH-1:0]  hist_q [DEPTH];
    logic signed [VEL_WIDTH-1:0]  hist_d [DEPTH];
    logic [PTR_W-1:0]             ptr_q, ptr_d;
    logic [FILL_W-1:0]            fill_q, fill_d;
    logic signed [SUM_W-1:0]      sum_q, sum_d;
    logic [STALL_W-1:0]           stall_q, stall_d;
    logic                         seen_q, seen_d;

    logic signed [COUNT_WIDTH-1:0] delta;
    logic signed [VEL_WIDTH-1:0]   clamped;
    logic                          clamp_hit;
    logic signed [SUM_W-1:0]       sum_next;
    logic                          seen_any;
    logic                          terminal;
    logic                          clear;

    always_comb begin
        // Modular subtraction: a wrap of the position counter needs no special case.
        delta     = $signed(encoder_count - base_q);
        clamped   = delta[VEL_WIDTH-1:0];
        clamp_hit = 1'b0;
        if (delta > VMAX) begin
            clamped   = VMAX[VEL_WIDTH-1:0];
            clamp_hit = 1'b1;
        end else if (delta < VMIN) begin
            clamped   = VMIN[VEL_WIDTH-1:0];
            clamp_hit = 1'b1;
        end
        // History starts zeroed, so subtracting the evicted slot is correct
        // even while the history is still filling.
        sum_next = sum_q + SUM_W'(clamped) - SUM_W'(hist_q[ptr_q]);
        seen_any = seen_q | state_change;
        terminal = (win_q == WIN_W'(WINDOW_CYCLES - 1));
    end

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        base_d      = base_q;
        velocity_d  = velocity_q;
        vel_valid_d = 1'b0;
        avg_d       = avg_q;
        avg_valid_d = avg_valid_q;
        sat_d       = sat_q;
        stalled_d   = stalled_q;
        hist_d      = hist_q;
        ptr_d       = ptr_q;
        fill_d      = fill_q;
        sum_d       = sum_q;
        stall_d     = stall_q;
        seen_d      = seen_q;
        clear       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clear = 1'b1;
                if (enable) begin
                    base_d  = encoder_count;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    // Partial window is abandoned without a sample.
                    clear   = 1'b1;
                    state_d = ST_IDLE;
                end else if (terminal) begin
                    win_d          = '0;
                    base_d         = encoder_count;
                    velocity_d     = clamped;
                    sat_d          = clamp_hit;
                    vel_valid_d    = 1'b1;
                    hist_d[ptr_q]  = clamped;
                    ptr_d          = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
                    sum_d          = sum_next;
                    avg_d          = VEL_WIDTH'(sum_next >>> AVG_LOG2);
                    if (fill_q != FILL_W'(DEPTH)) begin
                        fill_d = fill_q + 1'b1;
                    end
                    avg_valid_d = (fill_d == FILL_W'(DEPTH));
                    if (seen_any) begin
                        stall_d = '0;
                    end else if (stall_q != STALL_W'(STALL_WINDOWS)) begin
                        stall_d = stall_q + 1'b1;
                    end
                    stalled_d = (stall_d == STALL_W'(STALL_WINDOWS));
                    seen_d    = 1'b0;
                end else begin
                    win_d  = win_q + 1'b1;
                    seen_d = seen_any;
                    // Motion drops the stall flag immediately; the count
                    // itself is only reset at the window end.
                    stalled_d = (stall_q == STALL_W'(STALL_WINDOWS)) && !seen_any;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (clear) begin
            win_d       = '0;
            avg_valid_d = 1'b0;
            stalled_d   = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                hist_d[i] = '0;
            end
            ptr_d   = '0;
            fill_d  = '0;
            sum_d   = '0;
            stall_d = '0;
            seen_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            win_q       <= '0;
            base_q      <= '0;
            velocity_q  <= '0;
            vel_valid_q <= 1'b0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            stalled_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            ptr_q   <= '0;
            fill_q  <= '0;
            sum_q   <= '0;
            stall_q <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            base_q      <= base_d;
            velocity_q  <= velocity_d;
            vel_valid_q <= vel_valid_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            sat_q       <= sat_d;
            stalled_q   <= stalled_d;
            hist_q      <= hist_d;
            ptr_q       <= ptr_d;
            fill_q      <= fill_d;
            sum_q       <= sum_d;
            stall_q     <= stall_d;
            seen_q      <= seen_d;
        end
    end

    assign velocity       = velocity_q;
    assign velocity_valid = vel_valid_q;
    assign avg_velocity   = avg_q;
    assign avg_valid      = avg_valid_q;
    assign saturated      = sat_q;
    assign stalled        = stalled_q;
    assign state_dbg      = state_q;

endmodule
